// File: rtl/lpc_cycle_decoder_pkg.sv
// rtl/lpc_cycle_decoder_pkg.sv - LPC decoder state encoding, bus nibble codes and size decode
package lpc_cycle_decoder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CTDIR,
        ST_SIZE,
        ST_ADDR,
        ST_DATA,
        ST_TAR1,
        ST_TAR2,
        ST_SYNC,
        ST_TAR3,
        ST_TAR4
    } lpc_state_t;

    localparam logic [3:0] NIB_START  = 4'b0000;
    localparam logic [3:0] NIB_ABORT  = 4'b1111;
    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SWAIT = 4'b0101;
    localparam logic [3:0] SYNC_LWAIT = 4'b0110;
    localparam logic [3:0] SYNC_ERR   = 4'b1010;
    localparam logic [1:0] CT_IO      = 2'b00;
    localparam logic [1:0] CT_MEM     = 2'b01;
    localparam logic       DIR_WRITE  = 1'b1;

    // Returns 0 for the reserved size code so the caller can flag it
    function automatic logic [2:0] size_bytes(input logic [1:0] code);
        case (code)
            2'd0:    size_bytes = 3'd1;
            2'd1:    size_bytes = 3'd2;
            2'd3:    size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lpc_nibble_shift.sv
// rtl/lpc_nibble_shift.sv - 32-bit nibble accumulator with nibble counter for LPC address/data fields
module lpc_nibble_shift #(
    parameter bit LSN_FIRST = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [3:0]  nibble,
    output logic [31:0] value,
    output logic [3:0]  count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
            count <= '0;
        end else if (clear) begin
            value <= '0;
            count <= '0;
        end else if (shift) begin
            if (LSN_FIRST) begin
                // Nibble n lands at bits 4n+3:4n: low nibble of each byte first, bytes ascending
                if (!count[3]) value[{count[2:0], 2'b00} +: 4] <= nibble;
            end else begin
                value <= {value[27:0], nibble};
            end
            if (count != 4'hF) count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/lpc_cycle_decoder.sv
// rtl/lpc_cycle_decoder.sv - passive LPC I/O and memory cycle decoder emitting one record per cycle
module lpc_cycle_decoder
    import lpc_cycle_decoder_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 4,
    parameter int MAX_WAIT       = 255,
    parameter int WAIT_W         = 8
) (
    input  logic              lpc_clock,
    input  logic              lpc_reset,
    input  logic [3:0]        lpc_ad,
    input  logic              lpc_frame,
    output logic [3:0]        out_cyctype_dir,
    output logic [31:0]       out_addr,
    output logic [31:0]       out_data,
    output logic [2:0]        out_data_size,
    output logic [3:0]        out_sync,
    output logic [WAIT_W-1:0] out_wait_count,
    output logic              out_error,
    output logic              out_abort,
    output logic              out_clock_enable
);

    lpc_state_t state, state_next;

    logic start_hit, abort_hit, ctdir_take, size_take, addr_shift, data_shift;
    logic wait_hit, timeout, sync_take, sync_bad, emit;
    logic is_mem, dir, err_q, size_ok;
    logic [2:0] size_q, size_dec;
    logic [3:0] sync_q, addr_cnt, data_cnt, addr_last, data_last;
    logic [WAIT_W-1:0] wait_q, wait_inc;
    logic [31:0] addr_acc, data_acc;

    assign size_dec  = size_bytes(lpc_ad[1:0]);
    assign size_ok   = (size_dec != 3'd0) && (int'(size_dec) <= MAX_DATA_BYTES);
    assign wait_inc  = (&wait_q) ? wait_q : wait_q + 1'b1;
    assign addr_last = is_mem ? 4'd7 : 4'd3;
    assign data_last = {size_q, 1'b0} - 4'd1;

    lpc_nibble_shift #(.LSN_FIRST(1'b0)) u_addr (
        .clock (lpc_clock),
        .reset (lpc_reset),
        .clear (start_hit),
        .shift (addr_shift),
        .nibble(lpc_ad),
        .value (addr_acc),
        .count (addr_cnt)
    );

    lpc_nibble_shift #(.LSN_FIRST(1'b1)) u_data (
        .clock (lpc_clock),
        .reset (lpc_reset),
        .clear (start_hit),
        .shift (data_shift),
        .nibble(lpc_ad),
        .value (data_acc),
        .count (data_cnt)
    );

    always_ff @(posedge lpc_clock or posedge lpc_reset) begin
        if (lpc_reset) state <= ST_IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_hit  = 1'b0;
        abort_hit  = 1'b0;
        ctdir_take = 1'b0;
        size_take  = 1'b0;
        addr_shift = 1'b0;
        data_shift = 1'b0;
        wait_hit   = 1'b0;
        timeout    = 1'b0;
        sync_take  = 1'b0;
        sync_bad   = 1'b0;
        emit       = 1'b0;
        // LFRAME# low overrides whatever phase the cycle was in
        if (!lpc_frame) begin
            if (lpc_ad == NIB_START) begin
                start_hit  = 1'b1;
                state_next = ST_CTDIR;
            end else if (lpc_ad == NIB_ABORT) begin
                abort_hit  = 1'b1;
                state_next = ST_IDLE;
            end else begin
                state_next = ST_IDLE;
            end
        end else begin
            case (state)
                ST_IDLE: state_next = ST_IDLE;
                ST_CTDIR: begin
                    if (lpc_ad[3]) begin
                        state_next = ST_IDLE;
                    end else begin
                        ctdir_take = 1'b1;
                        state_next = (lpc_ad[3:2] == CT_MEM) ? ST_SIZE : ST_ADDR;
                    end
                end
                ST_SIZE: begin
                    size_take  = 1'b1;
                    state_next = ST_ADDR;
                end
                ST_ADDR: begin
                    addr_shift = 1'b1;
                    if (addr_cnt == addr_last)
                        state_next = (dir == DIR_WRITE) ? ST_DATA : ST_TAR1;
                end
                ST_DATA: begin
                    data_shift = 1'b1;
                    if (data_cnt == data_last)
                        state_next = (dir == DIR_WRITE) ? ST_TAR1 : ST_TAR3;
                end
                ST_TAR1: state_next = ST_TAR2;
                ST_TAR2: state_next = ST_SYNC;
                ST_SYNC: begin
                    sync_take = 1'b1;
                    case (lpc_ad)
                        SYNC_SWAIT, SYNC_LWAIT: begin
                            wait_hit = 1'b1;
                            if (int'(wait_q) >= MAX_WAIT) begin
                                timeout    = 1'b1;
                                state_next = ST_IDLE;
                            end
                        end
                        SYNC_READY: state_next = (dir == DIR_WRITE) ? ST_TAR3 : ST_DATA;
                        SYNC_ERR: begin
                            sync_bad   = 1'b1;
                            state_next = (dir == DIR_WRITE) ? ST_TAR3 : ST_DATA;
                        end
                        default: begin
                            sync_bad   = 1'b1;
                            state_next = (dir == DIR_WRITE) ? ST_TAR3 : ST_DATA;
                        end
                    endcase
                end
                ST_TAR3: state_next = ST_TAR4;
                ST_TAR4: begin
                    emit       = 1'b1;
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge lpc_clock or posedge lpc_reset) begin
        if (lpc_reset) begin
            is_mem           <= 1'b0;
            dir              <= 1'b0;
            err_q            <= 1'b0;
            size_q           <= 3'd1;
            sync_q           <= '0;
            wait_q           <= '0;
            out_cyctype_dir  <= '0;
            out_addr         <= '0;
            out_data         <= '0;
            out_data_size    <= '0;
            out_sync         <= '0;
            out_wait_count   <= '0;
            out_error        <= 1'b0;
            out_abort        <= 1'b0;
            out_clock_enable <= 1'b0;
        end else begin
            out_clock_enable <= emit | timeout;
            out_abort        <= abort_hit;
            if (start_hit) begin
                is_mem <= 1'b0;
                dir    <= 1'b0;
                err_q  <= 1'b0;
                size_q <= 3'd1;
                sync_q <= '0;
                wait_q <= '0;
            end
            if (ctdir_take) begin
                is_mem <= (lpc_ad[3:2] == CT_MEM);
                dir    <= lpc_ad[1];
                size_q <= 3'd1;
            end
            if (size_take) begin
                size_q <= size_ok ? size_dec : 3'd1;
                if (!size_ok) err_q <= 1'b1;
            end
            if (sync_take) sync_q <= lpc_ad;
            if (wait_hit)  wait_q <= wait_inc;
            if (sync_bad)  err_q  <= 1'b1;
            // A timeout reports the wait nibble that tripped it and drops the data field
            if (emit || timeout) begin
                out_cyctype_dir <= {(is_mem ? CT_MEM : CT_IO), dir, 1'b0};
                out_addr        <= addr_acc;
                out_data        <= timeout ? 32'd0 : data_acc;
                out_data_size   <= size_q;
                out_sync        <= timeout ? lpc_ad : sync_q;
                out_wait_count  <= timeout ? wait_inc : wait_q;
                out_error       <= timeout | err_q;
            end
        end
    end

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// tb/tb_lpc_cycle_decoder.sv - scoreboard bench for lpc_cycle_decoder with directed and random cycles
module tb_lpc_cycle_decoder;

    localparam int MAX_WAIT = 4;
    localparam int WAIT_W   = 8;

    logic              lpc_clock;
    logic              lpc_reset;
    logic [3:0]        lpc_ad;
    logic              lpc_frame;
    logic [3:0]        out_cyctype_dir;
    logic [31:0]       out_addr;
    logic [31:0]       out_data;
    logic [2:0]        out_data_size;
    logic [3:0]        out_sync;
    logic [WAIT_W-1:0] out_wait_count;
    logic              out_error;
    logic              out_abort;
    logic              out_clock_enable;

    lpc_cycle_decoder #(
        .MAX_DATA_BYTES(4),
        .MAX_WAIT      (MAX_WAIT),
        .WAIT_W        (WAIT_W)
    ) dut (
        .lpc_clock       (lpc_clock),
        .lpc_reset       (lpc_reset),
        .lpc_ad          (lpc_ad),
        .lpc_frame       (lpc_frame),
        .out_cyctype_dir (out_cyctype_dir),
        .out_addr        (out_addr),
        .out_data        (out_data),
        .out_data_size   (out_data_size),
        .out_sync        (out_sync),
        .out_wait_count  (out_wait_count),
        .out_error       (out_error),
        .out_abort       (out_abort),
        .out_clock_enable(out_clock_enable)
    );

    initial lpc_clock = 1'b0;
    always #5 lpc_clock = ~lpc_clock;

    typedef struct {
        bit        is_mem;
        bit        dir;
        bit [1:0]  size_code;
        bit [31:0] addr;
        bit [31:0] data;
        int        waits;
        bit [7:0]  wait_long;
        bit [3:0]  sync_final;
    } txn_t;

    typedef struct {
        bit [3:0]  ctdir;
        bit [31:0] addr;
        bit [31:0] data;
        bit [2:0]  size;
        bit [3:0]  sync;
        bit [7:0]  waits;
        bit        error;
    } rec_t;

    rec_t       exp_q[$];
    logic [4:0] bus_q[$];
    rec_t       mon_e;
    int n_checks = 0;
    int n_fail = 0;
    int abort_seen = 0;
    int abort_exp = 0;
    int strobes = 0;
    int n_sent = 0;
    bit prev_abort = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", name, act, req);
        end
    endtask

    function automatic txn_t mk(input bit m, input bit d, input bit [1:0] sc, input bit [31:0] a,
                                input bit [31:0] dt, input int w, input bit [7:0] wl, input bit [3:0] s);
        txn_t t;
        t.is_mem = m; t.dir = d; t.size_code = sc; t.addr = a; t.data = dt;
        t.waits = w; t.wait_long = wl; t.sync_final = s;
        return t;
    endfunction

    function automatic int nbytes_of(input txn_t t);
        if (!t.is_mem) return 1;
        case (t.size_code)
            2'd1:    return 2;
            2'd3:    return 4;
            default: return 1;
        endcase
    endfunction

    // Reference: what the record of a complete cycle must look like
    function automatic rec_t model(input txn_t t);
        rec_t r;
        int n;
        bit [31:0] mask;
        n = nbytes_of(t);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        r.ctdir = t.is_mem ? (t.dir ? 4'd6 : 4'd4) : (t.dir ? 4'd2 : 4'd0);
        r.addr  = t.is_mem ? t.addr : (t.addr & 32'h0000_FFFF);
        r.size  = 3'(n);
        if (t.waits > MAX_WAIT) begin
            r.data  = 32'd0;
            r.waits = 8'(MAX_WAIT + 1);
            r.sync  = t.wait_long[MAX_WAIT] ? 4'h6 : 4'h5;
            r.error = 1'b1;
        end else begin
            r.data  = t.data & mask;
            r.waits = 8'(t.waits);
            r.sync  = t.sync_final;
            r.error = (t.is_mem && t.size_code == 2'd2) || (t.sync_final != 4'h0);
        end
        return r;
    endfunction

    task automatic push_data(input txn_t t);
        for (int b = 0; b < nbytes_of(t); b++) begin
            bus_q.push_back({1'b1, t.data[8*b +: 4]});
            bus_q.push_back({1'b1, t.data[8*b+4 +: 4]});
        end
    endtask

    task automatic build(input txn_t t);
        bus_q.push_back(5'b0_0000);
        bus_q.push_back({1'b1, 1'b0, t.is_mem, t.dir, 1'b0});
        if (t.is_mem) bus_q.push_back({1'b1, 2'b00, t.size_code});
        for (int i = (t.is_mem ? 7 : 3); i >= 0; i--) bus_q.push_back({1'b1, t.addr[4*i +: 4]});
        if (t.dir) push_data(t);
        bus_q.push_back({1'b1, 4'($urandom)});
        bus_q.push_back({1'b1, 4'($urandom)});
        for (int w = 0; w < t.waits; w++) bus_q.push_back({1'b1, (t.wait_long[w] ? 4'h6 : 4'h5)});
        if (t.waits > MAX_WAIT) return;
        bus_q.push_back({1'b1, t.sync_final});
        if (!t.dir) push_data(t);
        bus_q.push_back({1'b1, 4'($urandom)});
        bus_q.push_back({1'b1, 4'($urandom)});
    endtask

    task automatic play();
        logic [4:0] nib;
        while (bus_q.size() > 0) begin
            nib = bus_q.pop_front();
            @(negedge lpc_clock);
            lpc_frame = nib[4];
            lpc_ad    = nib[3:0];
        end
    endtask

    task automatic send(input txn_t t);
        exp_q.push_back(model(t));
        n_sent++;
        build(t);
        play();
    endtask

    // Plays a cycle cut short after 'cut' nibbles, then optionally an abort nibble
    task automatic send_cut(input txn_t t, input int cut, input bit abort);
        int c;
        build(t);
        c = (cut < 0) ? int'($urandom_range(1, bus_q.size() - 1)) : cut;
        while (bus_q.size() > c) void'(bus_q.pop_back());
        if (abort) begin
            bus_q.push_back(5'b0_1111);
            abort_exp++;
        end
        play();
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.is_mem    = 1'($urandom);
        t.dir       = 1'($urandom);
        t.size_code = 2'($urandom);
        t.addr      = $urandom;
        t.data      = $urandom;
        t.waits     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(MAX_WAIT + 1, MAX_WAIT + 2))
                                                  : int'($urandom_range(0, MAX_WAIT));
        t.wait_long = 8'($urandom);
        case ($urandom_range(0, 5))
            4:       t.sync_final = 4'hA;
            5:       t.sync_final = 4'h3;
            default: t.sync_final = 4'h0;
        endcase
        return t;
    endfunction

    always @(negedge lpc_clock) begin
        if (lpc_reset) begin
            prev_abort = 1'b0;
        end else begin
            if (out_abort) begin
                abort_seen++;
                check("abort_one_cycle", 32'(prev_abort), 32'd0);
            end
            prev_abort = out_abort;
            if (out_clock_enable) begin
                strobes++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: actual addr %0h, required no strobe", out_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ctdir", 32'(out_cyctype_dir), 32'(mon_e.ctdir));
                    check("addr", out_addr, mon_e.addr);
                    check("data", out_data, mon_e.data);
                    check("size", 32'(out_data_size), 32'(mon_e.size));
                    check("sync", 32'(out_sync), 32'(mon_e.sync));
                    check("wait_count", 32'(out_wait_count), 32'(mon_e.waits));
                    check("error", 32'(out_error), 32'(mon_e.error));
                end
            end
        end
    end

    initial begin
        txn_t t;
        bit   mid;
        int   mode;
        lpc_reset = 1'b0;
        lpc_frame = 1'b1;
        lpc_ad    = 4'hF;
        #1 lpc_reset = 1'b1;
        repeat (2) @(negedge lpc_clock);
        check("reset_ctdir", 32'(out_cyctype_dir), 32'd0);
        check("reset_addr", out_addr, 32'd0);
        check("reset_data", out_data, 32'd0);
        check("reset_size", 32'(out_data_size), 32'd0);
        check("reset_wait", 32'(out_wait_count), 32'd0);
        check("reset_flags", {29'd0, out_error, out_abort, out_clock_enable}, 32'd0);
        lpc_reset = 1'b0;

        send(mk(1'b1, 1'b0, 2'd3, 32'haffe7fe5, 32'h1234df6c, 0, 8'h00, 4'h0));
        send(mk(1'b0, 1'b1, 2'd0, 32'h0000002e, 32'h0000005a, 3, 8'hFF, 4'h0));
        send(mk(1'b1, 1'b0, 2'd0, 32'h12345678, 32'h000000a5, 6, 8'h00, 4'h0));

        send_cut(mk(1'b1, 1'b0, 2'd3, 32'hfeed0001, 32'h0, 0, 8'h00, 4'h0), 7, 1'b1);
        send(mk(1'b0, 1'b0, 2'd0, 32'h000003f8, 32'h00000071, 1, 8'h00, 4'h0));
        check("abort_count_directed", 32'(abort_seen), 32'(abort_exp));

        send_cut(mk(1'b1, 1'b1, 2'd1, 32'h000c0000, 32'h0000beef, 0, 8'h00, 4'h0), 13, 1'b0);
        @(negedge lpc_clock);
        #2 lpc_reset = 1'b1;
        #1;
        check("async_reset_addr", out_addr, 32'd0);
        check("async_reset_data", out_data, 32'd0);
        check("async_reset_rest", {out_cyctype_dir, out_sync, out_wait_count, 5'd0, out_data_size,
                                   5'd0, out_error, out_abort, out_clock_enable}, 32'd0);
        lpc_frame = 1'b1;
        lpc_ad    = 4'hF;
        repeat (2) @(negedge lpc_clock);
        lpc_reset = 1'b0;
        send(mk(1'b1, 1'b1, 2'd1, 32'h000c0000, 32'h0000beef, 0, 8'h00, 4'h0));

        send(mk(1'b1, 1'b0, 2'd1, 32'h11112222, 32'h00003344, 0, 8'h00, 4'h0));
        send(mk(1'b1, 1'b0, 2'd3, 32'h33334444, 32'hcafef00d, 2, 8'h02, 4'h0));

        mid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            t = rand_txn();
            if (!mid) begin
                repeat ($urandom_range(0, 2)) bus_q.push_back(5'b1_1111);
                if ($urandom_range(0, 3) == 0) bus_q.push_back(5'b0_1101);
                if ($urandom_range(0, 3) == 0) bus_q.push_back(5'b0_0000);
                play();
            end
            mode = int'($urandom_range(0, 9));
            mid  = 1'b0;
            if (mode == 0 && t.waits <= MAX_WAIT) begin
                send_cut(t, -1, 1'b1);
            end else if (mode == 1 && t.waits <= MAX_WAIT) begin
                send_cut(t, -1, 1'b0);
                mid = 1'b1;
            end else begin
                send(t);
            end
        end
        if (mid) send(rand_txn());

        @(negedge lpc_clock);
        lpc_frame = 1'b1;
        lpc_ad    = 4'hF;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge lpc_clock);
        repeat (3) @(negedge lpc_clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("strobe_count", 32'(strobes), 32'(n_sent));
        check("abort_count", 32'(abort_seen), 32'(abort_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
